id_ex_ctrl_hazard: RTL and testbench

//  Parametrised decode/control for the ID stage, with hazard detection and a registered ID/EX control slice.

---
 rtl/mips_ctrl_pkg.sv | 40 ++++
 rtl/id_decoder.sv | 70 +++++++
 rtl/id_ex_ctrl_hazard.sv | 134 +++++++++++++
 tb/tb_id_ex_ctrl_hazard.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the ID-stage decode/control slice of the MIPS subset.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_XOR = 4'b0011;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX      = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       aluimm;
        logic       regrt;
        logic [3:0] aluc;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_decoder.sv
// Pure combinational decode of opcode/funct into the control bundle and source usage.
module id_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.wreg = 1'b1;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.aluc = ALUC_ADD;
                    FN_SUB:  ctrl.aluc = ALUC_SUB;
                    FN_AND:  ctrl.aluc = ALUC_AND;
                    FN_OR:   ctrl.aluc = ALUC_OR;
                    FN_XOR:  ctrl.aluc = ALUC_XOR;
                    FN_SLT:  ctrl.aluc = ALUC_SLT;
                    default: illegal   = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.wreg   = 1'b1;
                ctrl.m2reg  = 1'b1;
                ctrl.aluimm = 1'b1;
                ctrl.regrt  = 1'b1;
                ctrl.aluc   = ALUC_ADD;
                uses_rs     = 1'b1;
            end
            OP_SW: begin
                ctrl.wmem   = 1'b1;
                ctrl.aluimm = 1'b1;
                ctrl.aluc   = ALUC_ADD;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.wreg   = 1'b1;
                ctrl.aluimm = 1'b1;
                ctrl.regrt  = 1'b1;
                ctrl.aluc   = ALUC_ADD;
                uses_rs     = 1'b1;
            end
            OP_BEQ: begin
                ctrl.aluc = ALUC_SUB;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal encodings decode as a bubble with no register reads.
        if (illegal) begin
            ctrl    = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_ctrl_hazard.sv
// ID-stage control: hazard detection, forwarding selects, stall counter,
// registered ID/EX control slice and saturating illegal-instruction counter.
module id_ex_ctrl_hazard
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned ILL_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    input  logic                 flush,
    input  logic [REG_AW-1:0]    ex_dest,
    input  logic                 ex_wreg,
    input  logic                 ex_m2reg,
    input  logic [REG_AW-1:0]    mem_dest,
    input  logic                 mem_wreg,
    input  logic                 mem_m2reg,
    output logic                 stall,
    output logic                 e_valid,
    output logic                 e_wreg,
    output logic                 e_m2reg,
    output logic                 e_wmem,
    output logic                 e_aluimm,
    output logic                 e_regrt,
    output logic [3:0]           e_aluc,
    output logic [1:0]           e_fwda,
    output logic [1:0]           e_fwdb,
    output logic                 ill_pulse,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam int unsigned CNT_W = 3;

    ctrl_t             dec_ctrl;
    ctrl_t             e_ctrl;
    logic              uses_rs;
    logic              uses_rt;
    logic              dec_ill;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_live;
    logic              rt_live;
    logic              haz;
    logic [1:0]        fwda;
    logic [1:0]        fwdb;
    logic              issue;
    logic              ill_seen;
    logic [CNT_W-1:0]  cnt;
    logic              unused_imm;

    id_decoder u_dec (
        .op      (id_instr[31:26]),
        .funct   (id_instr[5:0]),
        .ctrl    (dec_ctrl),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .illegal (dec_ill)
    );

    assign rs         = REG_AW'(id_instr[25:21]);
    assign rt         = REG_AW'(id_instr[20:16]);
    assign unused_imm = ^id_instr[15:6];

    // EX ALU result beats MEM; a load still in EX cannot forward (that is the hazard case).
    function automatic logic [1:0] fwd_sel(
        input logic              live,
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] ed,
        input logic              ew,
        input logic              em,
        input logic [REG_AW-1:0] md,
        input logic              mw,
        input logic              mm
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (live && (src == ed) && ew && !em) begin
            sel = FWD_EX;
        end else if (live && (src == md) && mw) begin
            sel = mm ? FWD_MEM_LD : FWD_MEM_ALU;
        end
        return sel;
    endfunction

    always_comb begin
        rs_live  = id_valid & uses_rs & (rs != '0);
        rt_live  = id_valid & uses_rt & (rt != '0);
        haz      = ex_wreg & ex_m2reg & ((rs_live & (rs == ex_dest)) | (rt_live & (rt == ex_dest)));
        fwda     = fwd_sel(rs_live, rs, ex_dest, ex_wreg, ex_m2reg, mem_dest, mem_wreg, mem_m2reg);
        fwdb     = fwd_sel(rt_live, rt, ex_dest, ex_wreg, ex_m2reg, mem_dest, mem_wreg, mem_m2reg);
        stall    = rst_n & ~flush & (haz | (cnt != '0));
        issue    = id_valid & ~dec_ill & ~stall & ~flush;
        ill_seen = id_valid & dec_ill & ~stall & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            e_valid   <= 1'b0;
            e_ctrl    <= '0;
            e_fwda    <= FWD_RF;
            e_fwdb    <= FWD_RF;
            ill_pulse <= 1'b0;
            ill_cnt   <= '0;
        end else begin
            if (flush) begin
                cnt <= '0;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (haz) begin
                cnt <= CNT_W'(LOAD_STALL - 1);
            end
            e_valid   <= issue;
            e_ctrl    <= issue ? dec_ctrl : '0;
            e_fwda    <= issue ? fwda : FWD_RF;
            e_fwdb    <= issue ? fwdb : FWD_RF;
            ill_pulse <= ill_seen;
            if (ill_pulse && (ill_cnt != '1)) begin
                ill_cnt <= ill_cnt + 1'b1;
            end
        end
    end

    assign e_wreg   = e_ctrl.wreg;
    assign e_m2reg  = e_ctrl.m2reg;
    assign e_wmem   = e_ctrl.wmem;
    assign e_aluimm = e_ctrl.aluimm;
    assign e_regrt  = e_ctrl.regrt;
    assign e_aluc   = e_ctrl.aluc;

endmodule

// File: tb/tb_id_ex_ctrl_hazard.sv
// Scoreboard bench for id_ex_ctrl_hazard: directed scenarios then random traffic.
module tb_id_ex_ctrl_hazard;

    localparam int unsigned LOAD_STALL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_dest = '0;
    logic        ex_wreg = 1'b0;
    logic        ex_m2reg = 1'b0;
    logic [4:0]  mem_dest = '0;
    logic        mem_wreg = 1'b0;
    logic        mem_m2reg = 1'b0;
    logic        stall;
    logic        e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_regrt;
    logic [3:0]  e_aluc;
    logic [1:0]  e_fwda, e_fwdb;
    logic        ill_pulse;
    logic [7:0]  ill_cnt;

    always #5 clk = ~clk;

    id_ex_ctrl_hazard #(.REG_AW(5), .LOAD_STALL(LOAD_STALL), .ILL_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
        .ex_dest(ex_dest), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .mem_dest(mem_dest), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .stall(stall), .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
        .e_aluimm(e_aluimm), .e_regrt(e_regrt), .e_aluc(e_aluc), .e_fwda(e_fwda), .e_fwdb(e_fwdb),
        .ill_pulse(ill_pulse), .ill_cnt(ill_cnt)
    );

    typedef struct packed {
        logic       valid;
        logic       wreg, m2reg, wmem, aluimm, regrt;
        logic [3:0] aluc;
        logic [1:0] fwda, fwdb;
        logic       ill_pulse;
        logic [7:0] ill_cnt;
    } exp_t;

    typedef struct packed {
        logic       legal, rs_used, rt_used;
        logic       wreg, m2reg, wmem, aluimm, regrt;
        logic [3:0] aluc;
    } dec_t;

    exp_t rq[$];
    logic sq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_left = 0;   // guaranteed stall cycles still owed after the current one
    int   m_total = 0;  // illegal pulses emitted so far

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    // Reference decode table for the supported subset.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        logic [5:0] op;
        logic [5:0] fn;
        d  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'b000000: begin
                d.legal = 1'b1; d.rs_used = 1'b1; d.rt_used = 1'b1; d.wreg = 1'b1;
                case (fn)
                    6'b100000: d.aluc = 4'b0010;
                    6'b100010: d.aluc = 4'b0110;
                    6'b100100: d.aluc = 4'b0000;
                    6'b100101: d.aluc = 4'b0001;
                    6'b100110: d.aluc = 4'b0011;
                    6'b101010: d.aluc = 4'b0111;
                    default:   d = '0;
                endcase
            end
            6'b100011: begin
                d.legal = 1'b1; d.rs_used = 1'b1;
                d.wreg = 1'b1; d.m2reg = 1'b1; d.aluimm = 1'b1; d.regrt = 1'b1; d.aluc = 4'b0010;
            end
            6'b101011: begin
                d.legal = 1'b1; d.rs_used = 1'b1; d.rt_used = 1'b1;
                d.wmem = 1'b1; d.aluimm = 1'b1; d.aluc = 4'b0010;
            end
            6'b001000: begin
                d.legal = 1'b1; d.rs_used = 1'b1;
                d.wreg = 1'b1; d.aluimm = 1'b1; d.regrt = 1'b1; d.aluc = 4'b0010;
            end
            6'b000100: begin
                d.legal = 1'b1; d.rs_used = 1'b1; d.rt_used = 1'b1; d.aluc = 4'b0110;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic [4:0] ed, input logic ew,
                                           input logic em, input logic [4:0] md, input logic mw,
                                           input logic mm);
        if (src != 0 && src == ed && ew && !em) return 2'b01;
        if (src != 0 && src == md && mw) return mm ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    // Drive one cycle of inputs and push what the DUT must show for it.
    task automatic step(input logic rn, input logic v, input logic [31:0] ins, input logic fl,
                        input logic [4:0] ed, input logic ew, input logic em,
                        input logic [4:0] md, input logic mw, input logic mm);
        exp_t e;
        dec_t d;
        logic es, haz, iss;
        logic [4:0] rs, rt;
        @(negedge clk);
        rst_n = rn; id_valid = v; id_instr = ins; flush = fl;
        ex_dest = ed; ex_wreg = ew; ex_m2reg = em;
        mem_dest = md; mem_wreg = mw; mem_m2reg = mm;
        e  = '0;
        es = 1'b0;
        if (!rn) begin
            m_left  = 0;
            m_total = 0;
        end else begin
            d   = v ? ref_decode(ins) : dec_t'(0);
            rs  = ins[25:21];
            rt  = ins[20:16];
            haz = ew && em && ((d.rs_used && rs != 0 && rs == ed) || (d.rt_used && rt != 0 && rt == ed));
            if (fl) begin
                m_left = 0;
            end else begin
                es = haz || (m_left > 0);
                if (m_left > 0) m_left--;
                else if (haz) m_left = int'(LOAD_STALL) - 1;
            end
            iss = d.legal && !es && !fl;
            if (iss) begin
                e.valid = 1'b1; e.wreg = d.wreg; e.m2reg = d.m2reg; e.wmem = d.wmem;
                e.aluimm = d.aluimm; e.regrt = d.regrt; e.aluc = d.aluc;
                e.fwda = d.rs_used ? ref_fwd(rs, ed, ew, em, md, mw, mm) : 2'b00;
                e.fwdb = d.rt_used ? ref_fwd(rt, ed, ew, em, md, mw, mm) : 2'b00;
            end
            e.ill_pulse = v && !d.legal && !es && !fl;
            e.ill_cnt   = (m_total > 255) ? 8'd255 : 8'(m_total);
            m_total    += int'(e.ill_pulse);
        end
        sq.push_back(es);
        rq.push_back(e);
    endtask

    // Monitor: combinational stall, checked shortly after inputs settle.
    initial forever begin
        @(negedge clk);
        #3;
        if (sq.size() > 0) check("stall", 32'(stall), 32'(sq.pop_front()));
    end

    // Monitor: registered ID/EX slice and illegal counter, checked after each rising edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rq.size() > 0) begin
            e = rq.pop_front();
            check("ctrl", 32'({e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_regrt, e_aluc}),
                  32'({e.valid, e.wreg, e.m2reg, e.wmem, e.aluimm, e.regrt, e.aluc}));
            check("fwd", 32'({e_fwda, e_fwdb}), 32'({e.fwda, e.fwdb}));
            check("ill", 32'({ill_pulse, ill_cnt}), 32'({e.ill_pulse, e.ill_cnt}));
        end
    end

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    logic [5:0] fns [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010, 6'b000111};
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b111111, 6'b000010};

    initial begin
        logic [31:0] ins;
        logic [4:0]  ra, rb, rc;
        // Reset, then an issued ADDI so the slice holds a live instruction.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, itype(6'b001000, 5'd1, 5'd2), 0, 0, 0, 0, 0, 0, 0);
        // 1: reset in the middle of a load-use stall; afterwards no leftover stall.
        step(1, 1, rtype(6'b100000, 5'd2, 5'd4, 5'd3), 0, 5'd2, 1, 1, 0, 0, 0);
        step(0, 1, rtype(6'b100000, 5'd2, 5'd4, 5'd3), 0, 5'd2, 1, 1, 0, 0, 0);
        step(1, 1, rtype(6'b100000, 5'd2, 5'd4, 5'd3), 0, 0, 0, 0, 0, 0, 0);
        // 2: forward from EX ALU on both sources.
        step(1, 1, rtype(6'b100010, 5'd5, 5'd5, 5'd6), 0, 5'd5, 1, 0, 0, 0, 0);
        // 3: load-use with realistic pipeline advance.
        step(1, 1, rtype(6'b100000, 5'd7, 5'd0, 5'd1), 0, 5'd7, 1, 1, 0, 0, 0);
        step(1, 1, rtype(6'b100000, 5'd7, 5'd0, 5'd1), 0, 0, 0, 0, 5'd7, 1, 1);
        step(1, 1, rtype(6'b100000, 5'd7, 5'd0, 5'd1), 0, 0, 0, 0, 0, 0, 0);
        // 4: EX beats MEM, r0 never matches, MEM load and MEM ALU paths.
        step(1, 1, rtype(6'b100000, 5'd9, 5'd9, 5'd1), 0, 5'd9, 1, 0, 5'd9, 1, 0);
        step(1, 1, rtype(6'b100000, 5'd0, 5'd0, 5'd1), 0, 5'd0, 1, 0, 5'd0, 1, 0);
        step(1, 1, itype(6'b101011, 5'd9, 5'd3), 0, 0, 0, 0, 5'd9, 1, 1);
        step(1, 1, itype(6'b000100, 5'd4, 5'd9), 0, 0, 0, 0, 5'd9, 1, 0);
        // 5: flush during a stall clears the counter.
        step(1, 1, itype(6'b101011, 5'd1, 5'd7), 0, 5'd7, 1, 1, 0, 0, 0);
        step(1, 1, itype(6'b101011, 5'd1, 5'd7), 1, 5'd7, 1, 1, 0, 0, 0);
        step(1, 1, itype(6'b101011, 5'd1, 5'd7), 0, 0, 0, 0, 0, 0, 0);
        // 6: illegal stream saturates the counter; reset clears it.
        repeat (300) step(1, 1, {6'b111111, 26'd0}, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, {6'b111111, 26'd0}, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, {6'b111111, 26'd0}, 0, 0, 0, 0, 0, 0, 0);
        // Random traffic over a small register window to provoke matches.
        repeat (600) begin
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rc = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) ins = rtype(fns[$urandom_range(0, 6)], ra, rb, rc);
            else ins = itype(ops[$urandom_range(0, 5)], ra, rb);
            step(1, ($urandom_range(0, 7) != 0), ins, ($urandom_range(0, 11) == 0),
                 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        end
        repeat (2) @(negedge clk);
        #5;
        if (rq.size() != 0 || sq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", rq.size(), sq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
